segre_if_id_fifo: RTL and testbench
===================================

Name: segre_if_id_fifo

Overview:
- Parametrised IF/ID decoupling buffer; replaces the single-entry IF/ID register.
- Holds up to DEPTH fetched instruction/PC pairs so fetch can run ahead while decode stalls.
- Presents the head entry to the decode logic, with valid/ready backpressure to IF and a flush path that injects NOPs.
- Sits between the fetch stage and segre_decode.

Parameters:
- WORD_SIZE, 32, instruction width.
- ADDR_SIZE, 32, PC width.
- DEPTH, 4, number of entries; power of two, DEPTH >= 2.
- NOP_INSTR, 32'h00000013, instruction driven when the buffer is empty or flushed (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rsn_i  in  1  reset; asynchronous, active-low.
- instr_i  in  WORD_SIZE  instruction from IF.
- pc_i  in  ADDR_SIZE  PC of instr_i.
- valid_if_i  in  1  IF presents a valid instruction.
- ready_if_o  out  1  buffer accepts a push this cycle.
- block_id_i  in  1  decode stalled; head must not be popped.
- inject_nops_i  in  1  flush: discard all entries.
- instr_o  out  WORD_SIZE  head instruction, or NOP_INSTR when empty.
- pc_o  out  ADDR_SIZE  head PC, or last popped PC when empty.
- valid_id_o  out  1  instr_o/pc_o are a valid instruction.
- count_o  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage: circular buffer of DEPTH {instr, pc} entries.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count register is $clog2(DEPTH+1) bits.
- Reset (rsn_i low, asynchronous): count=0, wr_ptr=rd_ptr=0, pc hold register=0.
  - Outputs during reset: ready_if_o=1, valid_id_o=0, instr_o=NOP_INSTR, pc_o=0, count_o=0.
  - A reset mid-operation drops all entries immediately, without waiting for a clock edge.
- ready_if_o = (count != DEPTH). It depends only on registered state, with no combinational path from valid_if_i or block_id_i.
- push = valid_if_i && ready_if_o && !inject_nops_i.
- pop = valid_id_o && !block_id_i && !inject_nops_i.
- Outputs are combinational from registered state.
  - valid_id_o = (count != 0).
  - instr_o = entry[rd_ptr].instr when count != 0, else NOP_INSTR.
  - pc_o = entry[rd_ptr].pc when count != 0, else the pc hold register.
- Latency: a pushed entry is visible at the outputs the cycle after the push. There is no fall-through, even when empty.
- Pop: rd_ptr increments, count decrements, and the pc hold register loads the popped entry's PC.
- Simultaneous push and pop: both pointers advance and count is unchanged.
  - Allowed at any count between 1 and DEPTH-1.
  - At full, no push occurs (ready_if_o=0), so the pop alone frees a slot, which becomes available next cycle.
- Empty: pop is impossible (valid_id_o=0). block_id_i has no effect.
- Full: valid_if_i is ignored and IF must hold its instruction. The entries remain unchanged.
- Flush (inject_nops_i=1), which has priority over push and pop:
  - Next cycle: count=0 and rd_ptr=wr_ptr.
  - The pc hold register loads the current pc_o, so pc_o stays stable across the flush.
  - Any push or pop requested in the flush cycle is dropped.
- block_id_i and inject_nops_i together: the flush wins.
- No storage write occurs unless push=1. Entry contents after a flush are don't-care because they are masked by count.

Test Plan:
- Reset, then 3 pushes (pc 0x100, 0x104, 0x108) with block_id_i=1 -> count_o=3, ready_if_o=1, valid_id_o=1, pc_o=0x100 held.
- Continue with pc 0x10C, keeping block_id_i=1 -> count_o=4, ready_if_o=0; a further valid_if_i with pc 0x110 is not stored. Release block for 1 cycle -> pc_o=0x104, count_o=3, ready_if_o=1.
- Empty buffer, push pc 0x200 -> the same cycle shows valid_id_o=0 and instr_o=0x00000013; the next cycle shows valid_id_o=1 and pc_o=0x200.
- Streaming: push every cycle, pop every cycle, over 10 instructions (pc 0x300..0x324) -> count_o constant at 1, PCs emerge in order, and the pointers wrap without loss.
- Flush with count=3 while valid_if_i=1 (pc 0x400) -> next cycle count_o=0, valid_id_o=0, instr_o=NOP_INSTR, pc_o equal to the pre-flush head PC, and 0x400 not stored.
- Assert rsn_i low asynchronously mid-stream with count=2 -> valid_id_o=0, count_o=0 and pc_o=0 before the next clock edge; after release the first push appears after 1 cycle latency.

Source files
------------

// File: rtl/segre_if_id_fifo.sv
// IF/ID decoupling buffer: a DEPTH-entry circular queue of {instr, pc} pairs
// between fetch and decode, with valid/ready backpressure and a NOP-injecting flush.
module segre_if_id_fifo #(
    parameter int                   WORD_SIZE = 32,
    parameter int                   ADDR_SIZE = 32,
    parameter int                   DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                         clk_i,
    input  logic                         rsn_i,
    input  logic [WORD_SIZE-1:0]         instr_i,
    input  logic [ADDR_SIZE-1:0]         pc_i,
    input  logic                         valid_if_i,
    output logic                         ready_if_o,
    input  logic                         block_id_i,
    input  logic                         inject_nops_i,
    output logic [WORD_SIZE-1:0]         instr_o,
    output logic [ADDR_SIZE-1:0]         pc_o,
    output logic                         valid_id_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WORD_SIZE-1:0] instr_mem_q [DEPTH];
    logic [ADDR_SIZE-1:0] pc_mem_q    [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ADDR_SIZE-1:0] pc_hold_q, pc_hold_d;

    logic push;
    logic pop;

    assign ready_if_o = (count_q != CNT_W'(DEPTH));
    assign valid_id_o = (count_q != '0);
    assign instr_o    = valid_id_o ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    assign pc_o       = valid_id_o ? pc_mem_q[rd_ptr_q]    : pc_hold_q;
    assign count_o    = count_q;

    assign push = valid_if_i && ready_if_o && !inject_nops_i;
    assign pop  = valid_id_o && !block_id_i && !inject_nops_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pc_hold_d = pc_hold_q;

        if (inject_nops_i) begin
            // Hold the visible PC so decode sees a stable pc_o across the flush.
            count_d   = '0;
            rd_ptr_d  = wr_ptr_q;
            pc_hold_d = pc_o;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                pc_hold_d = pc_mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pc_hold_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pc_hold_q <= pc_hold_d;
        end
    end

    // Storage needs no reset: stale entries are always masked by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= instr_i;
            pc_mem_q[wr_ptr_q]    <= pc_i;
        end
    end

endmodule

// File: tb/tb_segre_if_id_fifo.sv
// Self-checking bench for segre_if_id_fifo: directed test-plan steps followed by
// a randomized phase, all compared against a queue-based reference model.
module tb_segre_if_id_fifo;

    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 32;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = $clog2(DEPTH+1);
    localparam logic [WORD_SIZE-1:0] NOP = 32'h00000013;

    typedef struct {
        logic [WORD_SIZE-1:0] instr;
        logic [ADDR_SIZE-1:0] pc;
    } entry_t;

    logic                 clk_i;
    logic                 rsn_i;
    logic [WORD_SIZE-1:0] instr_i;
    logic [ADDR_SIZE-1:0] pc_i;
    logic                 valid_if_i;
    logic                 ready_if_o;
    logic                 block_id_i;
    logic                 inject_nops_i;
    logic [WORD_SIZE-1:0] instr_o;
    logic [ADDR_SIZE-1:0] pc_o;
    logic                 valid_id_o;
    logic [CNT_W-1:0]     count_o;

    entry_t               model_q[$];
    logic [ADDR_SIZE-1:0] model_hold;
    int                   vectors;
    int                   miscompares;

    segre_if_id_fifo #(
        .WORD_SIZE(WORD_SIZE),
        .ADDR_SIZE(ADDR_SIZE),
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .instr_i      (instr_i),
        .pc_i         (pc_i),
        .valid_if_i   (valid_if_i),
        .ready_if_o   (ready_if_o),
        .block_id_i   (block_id_i),
        .inject_nops_i(inject_nops_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .valid_id_o   (valid_id_o),
        .count_o      (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic v, input logic [ADDR_SIZE-1:0] pc,
                                 input logic blk, input logic flush);
        valid_if_i    = v;
        pc_i          = pc;
        instr_i       = $urandom;
        block_id_i    = blk;
        inject_nops_i = flush;
    endtask

    function automatic logic [ADDR_SIZE-1:0] expPc();
        return (model_q.size() != 0) ? model_q[0].pc : model_hold;
    endfunction

    task automatic checkOutput(input string tag);
        logic                 e_valid;
        logic                 e_ready;
        logic [WORD_SIZE-1:0] e_instr;
        logic [ADDR_SIZE-1:0] e_pc;
        logic [CNT_W-1:0]     e_count;
        e_valid = (model_q.size() != 0);
        e_ready = (model_q.size() != DEPTH);
        e_instr = e_valid ? model_q[0].instr : NOP;
        e_pc    = expPc();
        e_count = CNT_W'(model_q.size());
        vectors += 5;
        assert (valid_id_o === e_valid) else begin
            miscompares++;
            $error("[TB] FAIL %s valid_id_o got %0b expected %0b", tag, valid_id_o, e_valid);
        end
        assert (ready_if_o === e_ready) else begin
            miscompares++;
            $error("[TB] FAIL %s ready_if_o got %0b expected %0b", tag, ready_if_o, e_ready);
        end
        assert (instr_o === e_instr) else begin
            miscompares++;
            $error("[TB] FAIL %s instr_o got %h expected %h", tag, instr_o, e_instr);
        end
        assert (pc_o === e_pc) else begin
            miscompares++;
            $error("[TB] FAIL %s pc_o got %h expected %h", tag, pc_o, e_pc);
        end
        assert (count_o === e_count) else begin
            miscompares++;
            $error("[TB] FAIL %s count_o got %0d expected %0d", tag, count_o, e_count);
        end
    endtask

    // Check the current outputs, clock once, then advance the model by the queue rules.
    task automatic step(input string tag);
        entry_t e;
        logic   do_push;
        logic   do_pop;
        checkOutput(tag);
        do_push = valid_if_i && (model_q.size() != DEPTH) && !inject_nops_i;
        do_pop  = (model_q.size() != 0) && !block_id_i && !inject_nops_i;
        e.instr = instr_i;
        e.pc    = pc_i;
        @(posedge clk_i);
        #1;
        if (inject_nops_i) begin
            model_hold = expPc();
            model_q.delete();
        end else begin
            if (do_pop) begin
                model_hold = model_q[0].pc;
                void'(model_q.pop_front());
            end
            if (do_push) model_q.push_back(e);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_hold  = '0;
        rsn_i       = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        #12;
        checkOutput("reset");
        rsn_i = 1'b1;
        #1;

        // Fill with decode blocked, then try to overfill.
        step("fill0"); // idle cycle after reset release
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0); step("push100");
        applyStimulus(1'b1, 32'h104, 1'b1, 1'b0); step("push104");
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b0); step("push108");
        applyStimulus(1'b1, 32'h10C, 1'b1, 1'b0); step("push10c");
        applyStimulus(1'b1, 32'h110, 1'b1, 1'b0); step("full110");
        applyStimulus(1'b1, 32'h110, 1'b0, 1'b0); step("release");
        applyStimulus(1'b0, 32'h0,   1'b1, 1'b0); step("after_pop");

        // Drain, then check the no-fall-through latency.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0); step("drain");
        end
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0); step("push200");
        applyStimulus(1'b0, 32'h0,   1'b1, 1'b0); step("see200");
        applyStimulus(1'b0, 32'h0,   1'b0, 1'b0); step("pop200");

        // Streaming push and pop every cycle across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4*i), 1'b0, 1'b0); step("stream");
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0); step("stream_end");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0); step("stream_empty");

        // Flush at count=3 with a competing push.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h380 + 32'(4*i), 1'b1, 1'b0); step("preflush");
        end
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b1); step("flush");
        applyStimulus(1'b0, 32'h0,   1'b0, 1'b0); step("postflush");
        applyStimulus(1'b0, 32'h0,   1'b0, 1'b0); step("postflush2");

        // Asynchronous reset between clock edges with count=2.
        applyStimulus(1'b1, 32'h480, 1'b1, 1'b0); step("prerst0");
        applyStimulus(1'b1, 32'h484, 1'b1, 1'b0); step("prerst1");
        applyStimulus(1'b0, 32'h0,   1'b1, 1'b0);
        checkOutput("prerst2");
        #1 rsn_i = 1'b0;
        #1;
        model_q.delete();
        model_hold = '0;
        checkOutput("async_rst");
        #1 rsn_i = 1'b1;
        #1;
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0); step("push500");
        applyStimulus(1'b0, 32'h0,   1'b1, 1'b0); step("see500");
        applyStimulus(1'b0, 32'h0,   1'b0, 1'b0); step("pop500");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom,
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 15) == 0));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
